can_acceptance_filter_n: RTL

//  Parametrised N-filter acceptance filter between the CAN RX bit-stream core and the RX FIFO.
//  - Snapshots each received message and its filter configuration.
//  - Compares the ID word against NUM_FILTERS mask/ID pairs and writes accepted messages to the RX FIFO.
//  - Stalls on FIFO full and reports the lowest matching filter index.

---
 rtl/can_acf_pkg.sv | 29 ++
 rtl/acf_match_unit.sv | 16 +
 rtl/can_acceptance_filter_n.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/can_acf_pkg.sv
// Shared types and helpers for the CAN acceptance filter.
// Used by can_acceptance_filter_n; see that file for the ACF_DROP_COUNT_EN build option.
package can_acf_pkg;

  // Upper bound on filter count and the matching index width
  localparam int ACF_MAX_FILTERS = 16;
  localparam int ACF_IDX_MAX_W   = 4;
  localparam int ACF_DROP_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    WRITE   = 2'd2,
    DISCARD = 2'd3
  } acf_state_t;

  // Priority encoder: index of the lowest set bit, 0 when no bit is set
  function automatic logic [ACF_IDX_MAX_W-1:0] acf_lowest_idx(
    input logic [ACF_MAX_FILTERS-1:0] hit
  );
    logic [ACF_IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int k = ACF_MAX_FILTERS - 1; k >= 0; k--) begin
      if (hit[k]) idx = ACF_IDX_MAX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/acf_match_unit.sv
// Single mask/ID filter compare. Purely combinational: the ID matches when
// every bit selected by the mask agrees with the filter ID. A zero mask
// therefore matches any ID. A disabled filter never matches.
module acf_match_unit #(
  parameter int ID_W = 32
) (
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] mask,
  input  logic [ID_W-1:0] filt_id,
  input  logic            enable,
  output logic            hit
);

  assign hit = enable & ((id & mask) == (filt_id & mask));

endmodule

// File: rtl/can_acceptance_filter_n.sv
// N-filter CAN acceptance filter between the RX bit-stream core and the RX FIFO.
// A message and its filter configuration are snapshotted on the input
// handshake, compared against all enabled filters, and either written to the
// FIFO (stalling while it is full) or discarded.
// Build option: define ACF_DROP_COUNT_EN to add a saturating discard counter
// (o_drop_cnt) with a synchronous clear input (i_drop_clr).
module can_acceptance_filter_n
  import can_acf_pkg::*;
#(
  parameter  int NUM_FILTERS = 4,
  parameter  int MSG_W       = 128,
  parameter  int ID_W        = 32,
  localparam int IDX_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                        i_sys_clk,
  input  logic                        i_reset_n,
  input  logic                        i_msg_valid,
  output logic                        o_msg_ready,
  input  logic [MSG_W-1:0]            i_rx_message,
  input  logic [NUM_FILTERS*ID_W-1:0] i_afmr,
  input  logic [NUM_FILTERS*ID_W-1:0] i_afir,
  input  logic [NUM_FILTERS-1:0]      i_uaf,
  input  logic                        i_rx_full,
  output logic                        o_rx_w_en,
  output logic [MSG_W-1:0]            o_rx_fifo_w_data,
  output logic                        o_acfbsy,
  output logic                        o_match_hit,
`ifdef ACF_DROP_COUNT_EN
  input  logic                        i_drop_clr,
  output logic [ACF_DROP_CNT_W-1:0]   o_drop_cnt,
`endif
  output logic [IDX_W-1:0]            o_match_idx
);

  acf_state_t state_reg, state_next;

  // Snapshot of the message and configuration taken at the handshake
  logic [MSG_W-1:0]            msg_reg;
  logic [NUM_FILTERS*ID_W-1:0] afmr_reg;
  logic [NUM_FILTERS*ID_W-1:0] afir_reg;
  logic [NUM_FILTERS-1:0]      uaf_reg;

  // Compare result registered in COMPARE, published on the FIFO write
  logic             hit_any_reg;
  logic [IDX_W-1:0] hit_idx_reg;
  logic             match_hit_reg;
  logic [IDX_W-1:0] match_idx_reg;

  logic [ID_W-1:0]            id_word;
  logic [NUM_FILTERS-1:0]     hit_vec;
  logic [ACF_MAX_FILTERS-1:0] hit_pad;
  logic [IDX_W-1:0]           idx_next;

  logic capture;
  logic write_fire;
  logic drop_entry;

  assign id_word = msg_reg[MSG_W-1 -: ID_W];

  // One compare unit per filter, all working on the captured ID word
  generate
    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_filter
      acf_match_unit #(
        .ID_W (ID_W)
      ) u_match (
        .id      (id_word),
        .mask    (afmr_reg[gi*ID_W +: ID_W]),
        .filt_id (afir_reg[gi*ID_W +: ID_W]),
        .enable  (uaf_reg[gi]),
        .hit     (hit_vec[gi])
      );
    end
  endgenerate

  // Widen the hit vector to the encoder width; unused upper filters never hit
  always_comb begin
    hit_pad                  = '0;
    hit_pad[NUM_FILTERS-1:0] = hit_vec;
  end

  assign idx_next = IDX_W'(acf_lowest_idx(hit_pad));

  // State register
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and handshake/strobe outputs
  always_comb begin
    state_next  = state_reg;
    o_msg_ready = 1'b0;
    o_rx_w_en   = 1'b0;
    capture     = 1'b0;
    write_fire  = 1'b0;
    drop_entry  = 1'b0;
    case (state_reg)
      IDLE: begin
        o_msg_ready = 1'b1;
        if (i_msg_valid) begin
          capture    = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        // With no filter enabled every message is accepted
        if (uaf_reg == '0 || (|hit_vec)) begin
          state_next = WRITE;
        end else begin
          state_next = DISCARD;
          drop_entry = 1'b1;
        end
      end
      WRITE: begin
        if (!i_rx_full) begin
          o_rx_w_en  = 1'b1;
          write_fire = 1'b1;
          state_next = IDLE;
        end
      end
      DISCARD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Message and configuration snapshot on the input handshake
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      msg_reg  <= '0;
      afmr_reg <= '0;
      afir_reg <= '0;
      uaf_reg  <= '0;
    end else if (capture) begin
      msg_reg  <= i_rx_message;
      afmr_reg <= i_afmr;
      afir_reg <= i_afir;
      uaf_reg  <= i_uaf;
    end
  end

  // Register the compare result while in COMPARE
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hit_any_reg <= 1'b0;
      hit_idx_reg <= '0;
    end else if (state_reg == COMPARE) begin
      hit_any_reg <= |hit_vec;
      hit_idx_reg <= (|hit_vec) ? idx_next : '0;
    end
  end

  // Publish match status only when a message actually reaches the FIFO
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      match_hit_reg <= 1'b0;
      match_idx_reg <= '0;
    end else if (write_fire) begin
      match_hit_reg <= hit_any_reg;
      match_idx_reg <= hit_idx_reg;
    end
  end

  assign o_rx_fifo_w_data = msg_reg;
  assign o_acfbsy         = (state_reg != IDLE);
  assign o_match_hit      = match_hit_reg;
  assign o_match_idx      = match_idx_reg;

`ifdef ACF_DROP_COUNT_EN
  logic [ACF_DROP_CNT_W-1:0] drop_cnt_reg;

  // Saturating discard counter; clear takes priority over an increment
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      drop_cnt_reg <= '0;
    end else if (i_drop_clr) begin
      drop_cnt_reg <= '0;
    end else if (drop_entry && (drop_cnt_reg != {ACF_DROP_CNT_W{1'b1}})) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign o_drop_cnt = drop_cnt_reg;
`endif

endmodule
